uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, 16, idle clk cycles inserted after each frame, range 0..255.
REQ-002 Parameter TIMEOUT_CYCLES, 1048576, max clk cycles Tx_EN may stay high per frame, range 1..2^20.
REQ-003 Port clk  in  1  single system clock; all logic on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port req_valid  in  4  requester i has a byte pending.
REQ-006 Port req_data  in  32  requester i byte at bits [8i+7:8i].
REQ-007 Port req_ready  out  4  one-hot, one-cycle pulse: requester i byte accepted.
REQ-008 Port baud_select  in  3  baud code applied to the next frame.
REQ-009 Port Tx_DATA  out  8  byte to transmitter.
REQ-010 Port Tx_WR  out  1  one-cycle load strobe for Tx_DATA.
REQ-011 Port Tx_EN  out  1  transmitter enable, high for the whole frame.
REQ-012 Port Tx_baud_select  out  3  baud code to transmitter baud controller.
REQ-013 Port Tx_BUSY  in  1  transmitter busy; high from start bit to stop bit.
REQ-014 Port sched_busy  out  1  high in every state except IDLE.
REQ-015 Port active_id  out  2  index of the requester currently granted.
REQ-016 Port tx_timeout  out  1  one-cycle pulse on frame abort.

Function
REQ-017 States SHALL be IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP; all outputs registered.
REQ-018 IDLE: arbitrate only when |req_valid and Tx_BUSY=0; otherwise remain in IDLE.
REQ-019 Arbitration SHALL be round-robin, searching from last_grant+1 mod 4; last_grant resets to 3.
REQ-020 Arbitration in cycle t SHALL sample req_data and baud_select at t; LOAD in t+1 drives Tx_WR=1, req_ready[w]=1, Tx_DATA and Tx_baud_select valid.
REQ-021 Tx_WR and req_ready SHALL be high for exactly one cycle per frame.
REQ-022 Tx_DATA, Tx_baud_select and active_id SHALL hold constant from LOAD until the next LOAD.
REQ-023 START (t+2): Tx_EN=1; Tx_EN SHALL remain high through WAIT_BUSY and WAIT_DONE.
REQ-024 WAIT_BUSY -> WAIT_DONE on Tx_BUSY=1; WAIT_DONE -> GAP on Tx_BUSY=0; Tx_EN=0 in the first GAP cycle.
REQ-025 GAP SHALL last GAP_CYCLES cycles, then IDLE; GAP_CYCLES=0 SHALL go from WAIT_DONE straight to IDLE.
REQ-026 A requester deasserting req_valid before arbitration SHALL lose no state and get no req_ready.
REQ-027 Changes on req_valid, req_data and baud_select after arbitration SHALL not affect the frame in flight.
REQ-028 Back-to-back: with all four requesters valid, grant order SHALL be 0,1,2,3,0,...

Reset
REQ-029 On reset=1 at a clock edge: state=IDLE, last_grant=3, Tx_EN=0, Tx_WR=0, req_ready=0, Tx_DATA=0, Tx_baud_select=0, active_id=0, sched_busy=0, tx_timeout=0, counters=0.
REQ-030 Reset mid-frame SHALL drop Tx_EN on the next edge; no req_ready, no tx_timeout.

Configuration
REQ-031 Macro UART_TX_SCHED_TIMEOUT_EN defined: a 20-bit counter runs while Tx_EN=1; on reaching TIMEOUT_CYCLES, Tx_EN=0, tx_timeout pulses one cycle, state goes to GAP.
REQ-032 Macro undefined: no counter, tx_timeout tied 0, WAIT_BUSY/WAIT_DONE wait indefinitely.

Verification
REQ-033 Single request: req_valid=4'b0010, req_data[15:8]=8'hA5, baud=3'd3 -> t+1 Tx_WR=1, Tx_DATA=8'hA5, req_ready=4'b0010, Tx_baud_select=3; t+2 Tx_EN=1.
REQ-034 All four valid, bytes 8'h10..8'h13, transmitter model -> four frames, data order 10,11,12,13, GAP_CYCLES idle cycles between frames.
REQ-035 Tx_BUSY held 1 in IDLE with req_valid=4'b0001 -> no Tx_WR until Tx_BUSY=0, then grant within 1 cycle.
REQ-036 reset=1 during WAIT_DONE -> next edge Tx_EN=0, sched_busy=0; next grant goes to requester 0.
REQ-037 With UART_TX_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, Tx_BUSY stuck 0 -> tx_timeout pulse 100 cycles after Tx_EN rise, Tx_EN=0; without macro, Tx_EN stays 1.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Purpose : round-robin scheduler that feeds bytes from four requesters to a UART transmitter, one frame at a time.
// Latency : a grant in IDLE cycle t loads the byte in cycle t+1 (Tx_WR, req_ready), and Tx_EN rises in cycle t+2.
// Backpress: a grant is made only in IDLE with Tx_BUSY low. The frame holds until Tx_BUSY rises and then falls, followed by GAP_CYCLES idle cycles.
//
// Ports:
//   clk, reset            - system clock; synchronous active-high reset
//   req_valid[3:0]        - requester i has a byte pending
//   req_data[31:0]        - requester i byte at [8i+7:8i]
//   req_ready[3:0]        - one-hot, one-cycle accept pulse
//   baud_select[2:0]      - baud code captured with the grant
//   Tx_DATA, Tx_WR        - byte and load strobe to the transmitter
//   Tx_EN                 - transmitter enable, high for the whole frame
//   Tx_baud_select[2:0]   - baud code to the transmitter baud controller
//   Tx_BUSY               - transmitter busy, from start bit to stop bit
//   sched_busy            - high in every state except IDLE
//   active_id[1:0]        - requester currently granted
//   tx_timeout            - one-cycle pulse on frame abort
// Optional feature: defining UART_TX_SCHED_TIMEOUT_EN aborts any frame whose
// Tx_EN has been high for TIMEOUT_CYCLES cycles.
module uart_tx_scheduler #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  input  logic [2:0]  baud_select,
  output logic [7:0]  Tx_DATA,
  output logic        Tx_WR,
  output logic        Tx_EN,
  output logic [2:0]  Tx_baud_select,
  input  logic        Tx_BUSY,
  output logic        sched_busy,
  output logic [1:0]  active_id,
  output logic        tx_timeout
);

  // Out-of-range parameters stop elaboration instead of silently wrapping counters.
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048576) begin : g_bad_params
    $error("uart_tx_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam bit         GAP_NONE = (GAP_CYCLES == 0);

  state_t     state;
  logic [1:0] last_grant;
  logic [7:0] gap_cnt;
  logic       to_hit;

  // Round-robin search starting one past the last winner. When k = 4, the
  // search wraps back to last_grant itself, which is then the lowest priority.
  logic [1:0] grant_idx;
  logic       grant_vld;
  logic [1:0] cand;

  always_comb begin
    grant_idx = last_grant;
    grant_vld = 1'b0;
    cand      = last_grant;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

  logic [19:0] to_cnt;

  // to_cnt holds the number of cycles for which Tx_EN has already been high.
  // The abort fires on the cycle that would exceed the budget.
  assign to_hit = Tx_EN && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt     <= '0;
      tx_timeout <= 1'b0;
    end else begin
      tx_timeout <= to_hit;
      if (Tx_EN && !to_hit) begin
        to_cnt <= to_cnt + 20'd1;
      end else begin
        to_cnt <= '0;
      end
    end
  end
`else
  assign to_hit     = 1'b0;
  assign tx_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= 2'd3;
      gap_cnt        <= '0;
      Tx_EN          <= 1'b0;
      Tx_WR          <= 1'b0;
      req_ready      <= '0;
      Tx_DATA        <= '0;
      Tx_baud_select <= '0;
      active_id      <= '0;
      sched_busy     <= 1'b0;
    end else begin
      Tx_WR     <= 1'b0;
      req_ready <= '0;
      unique case (state)
        IDLE: begin
          // Byte and baud are captured here, so later input changes cannot
          // disturb the frame in flight.
          if (grant_vld && !Tx_BUSY) begin
            state          <= LOAD;
            sched_busy     <= 1'b1;
            last_grant     <= grant_idx;
            active_id      <= grant_idx;
            Tx_DATA        <= req_data[{grant_idx, 3'b000} +: 8];
            Tx_baud_select <= baud_select;
            Tx_WR          <= 1'b1;
            req_ready      <= 4'b0001 << grant_idx;
          end
        end
        LOAD: begin
          state <= START;
          Tx_EN <= 1'b1;
        end
        START, WAIT_BUSY, WAIT_DONE: begin
          // A normal end of frame and a timeout abort leave through the same path.
          if (to_hit || (state == WAIT_DONE && !Tx_BUSY)) begin
            Tx_EN   <= 1'b0;
            gap_cnt <= '0;
            if (GAP_NONE) begin
              state      <= IDLE;
              sched_busy <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else if (state == START) begin
            state <= WAIT_BUSY;
          end else if (state == WAIT_BUSY && Tx_BUSY) begin
            state <= WAIT_DONE;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state      <= IDLE;
            sched_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state      <= IDLE;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose : randomized and directed bench for uart_tx_scheduler against a frame-timeline reference model.
// Latency : outputs are checked every cycle, 1 time unit after the rising edge.
// Backpress: the bench plays the transmitter: a scheduled Tx_BUSY pulse per frame, plus spurious busy outside frames.
module tb_uart_tx_scheduler;
  localparam int GAP = 3;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [2:0]  baud_select;
  logic [7:0]  Tx_DATA;
  logic        Tx_WR;
  logic        Tx_EN;
  logic [2:0]  Tx_baud_select;
  logic        Tx_BUSY;
  logic        sched_busy;
  logic [1:0]  active_id;
  logic        tx_timeout;

  uart_tx_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .baud_select(baud_select), .Tx_DATA(Tx_DATA),
    .Tx_WR(Tx_WR), .Tx_EN(Tx_EN), .Tx_baud_select(Tx_baud_select),
    .Tx_BUSY(Tx_BUSY), .sched_busy(sched_busy), .active_id(active_id),
    .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n;

  // Frame timeline of the current or most recent frame, in absolute cycle numbers.
  int ready_at, g_wr, en_lo, en_hi, gap_hi, to_cyc, busy_lo, busy_hi, last;
  logic [7:0] pend_data, hold_data;
  logic [2:0] pend_baud, hold_baud;
  logic [1:0] pend_id, hold_id;

  // Stimulus controls.
  bit         use_fix, stuck, rst_req;
  int         spur;  // 0: idle-low, 1: random busy outside frames, 2: forced busy outside frames
  logic [3:0]  fix_valid;
  logic [31:0] fix_data;
  logic [2:0]  fix_baud;

  logic [7:0] wr_log[$];
  int         to_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic check_outputs();
    if (n == g_wr) begin
      hold_data = pend_data;
      hold_baud = pend_baud;
      hold_id   = pend_id;
    end
    chk("tx_wr",      Tx_WR,          n == g_wr);
    chk("req_ready",  req_ready,      (n == g_wr) ? (32'd1 << pend_id) : 32'd0);
    chk("tx_data",    Tx_DATA,        hold_data);
    chk("tx_baud",    Tx_baud_select, hold_baud);
    chk("active_id",  active_id,      hold_id);
    chk("tx_en",      Tx_EN,          n >= en_lo && n <= en_hi);
    chk("sched_busy", sched_busy,     n >= g_wr && n <= gap_hi);
    chk("tx_timeout", tx_timeout,     n == to_cyc);
    if (Tx_WR) wr_log.push_back(Tx_DATA);
    if (tx_timeout) to_seen++;
  endtask

  task automatic clear_frame();
    g_wr = -100; en_lo = -100; en_hi = -100; gap_hi = -100;
    to_cyc = -100; busy_lo = -100; busy_hi = -100;
  endtask

  task automatic drive_and_model();
    bit in_frame;
    int w;
    in_frame = (n >= g_wr && n <= en_hi);
    reset = rst_req;
    if (n >= busy_lo && n <= busy_hi) Tx_BUSY = 1'b1;
    else if (in_frame)                Tx_BUSY = 1'b0;
    else if (spur == 2)               Tx_BUSY = 1'b1;
    else if (spur == 1)               Tx_BUSY = ($urandom_range(3) == 0);
    else                              Tx_BUSY = 1'b0;
    if (use_fix) begin
      req_valid = fix_valid; req_data = fix_data; baud_select = fix_baud;
    end else begin
      req_valid   = ($urandom_range(3) == 0) ? 4'b0 : 4'($urandom_range(15));
      req_data    = $urandom;
      baud_select = 3'($urandom_range(7));
    end
    if (rst_req) begin
      last = 3;
      hold_data = '0; hold_baud = '0; hold_id = '0;
      clear_frame();
      ready_at = n + 1;
    end else if (n >= ready_at && req_valid != 4'b0 && !Tx_BUSY) begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && req_valid[(last + k) % 4]) w = (last + k) % 4;
      last      = w;
      pend_id   = 2'(w);
      pend_data = req_data[8*w +: 8];
      pend_baud = baud_select;
      g_wr  = n + 1;
      en_lo = n + 2;
      if (stuck) begin
        busy_lo = -100; busy_hi = -100;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        en_hi  = n + 1 + TO;
        to_cyc = en_hi + 1;
`else
        en_hi  = 1 << 30;
        to_cyc = -100;
`endif
      end else begin
        busy_lo = n + 3 + int'($urandom_range(3));
        busy_hi = busy_lo + int'($urandom_range(4));
        en_hi   = busy_hi + 1;
        to_cyc  = -100;
      end
      gap_hi   = en_hi + GAP;
      ready_at = gap_hi + 1;
    end
  endtask

  task automatic run_cycle();
    check_outputs();
    drive_and_model();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++) run_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int guard;
    reset = 1'b1; req_valid = '0; req_data = '0; baud_select = '0; Tx_BUSY = 1'b0;
    n = 0; last = 3; ready_at = 0; clear_frame();
    pend_data = '0; pend_baud = '0; pend_id = '0;
    hold_data = '0; hold_baud = '0; hold_id = '0;
    use_fix = 1; stuck = 0; rst_req = 0; spur = 0;
    fix_valid = '0; fix_data = '0; fix_baud = '0;
    repeat (2) @(posedge clk);
    #1;

    // Single request from requester 1. The first check covers the reset state.
    fix_valid = 4'b0010; fix_data = 32'h0000_A500; fix_baud = 3'd3;
    run_cycle();
    fix_valid = 4'b0; fix_data = $urandom; fix_baud = 3'd6;
    run(30);
    chk("single_count", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("single_data", wr_log[0], 8'hA5);

    // Transmitter busy in IDLE holds off the grant.
    fix_valid = 4'b0001; fix_data = 32'h0000_0077; fix_baud = 3'd1; spur = 2;
    run(8);
    chk("busy_holdoff", wr_log.size(), 1);
    spur = 0;
    run_cycle();
    fix_valid = 4'b0;
    run(30);
    chk("busy_release_count", wr_log.size(), 2);

    // Random traffic with spurious transmitter busy outside frames.
    use_fix = 0; spur = 1;
    run(600);

    // Reset while in WAIT_DONE, then four back-to-back requesters.
    use_fix = 1; spur = 0; fix_valid = 4'hF; fix_data = 32'h1312_1110; fix_baud = 3'd5;
    guard = 0;
    while (!(busy_lo >= 0 && n == busy_lo + 1) && guard < 200) begin
      run_cycle();
      guard++;
    end
    chk("reach_wait_done", guard < 200, 1);
    rst_req = 1;
    run_cycle();
    rst_req = 0;
    wr_log.delete();
    run(70);
    chk("rr_count", wr_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      if (i < wr_log.size()) chk("rr_order", wr_log[i], 32'h10 + i);
    fix_valid = 4'b0;
    run(40);

    // Transmitter never asserts busy.
    stuck = 1; fix_valid = 4'b0100; fix_data = 32'h00C3_0000; fix_baud = 3'd2;
    run_cycle();
    fix_valid = 4'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    run(130);
    chk("timeout_pulses", to_seen, 1);
`else
    run(150);
    chk("tx_en_stuck", Tx_EN, 1);
    chk("no_timeout", to_seen, 0);
    rst_req = 1;
    run_cycle();
    rst_req = 0;
`endif
    stuck = 0;
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
